// File: rtl/soc_system_dp_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_dp_ram_pipelined
// Brief    : True-dual-port Avalon-MM scratchpad RAM with byte enables, a
//            post-reset clear sequencer, a 1- or 2-cycle read pipeline, and
//            deterministic same-address collision resolution between ports.
// Revision : 1.0 - initial parametrised release
// ============================================================================

// ----------------------------------------------------------------------------
// Read-return pipeline for one port: delays the accepted-read strobe and the
// word captured at the accept edge by READ_LATENCY cycles. Readdata holds its
// last returned value between pulses.
// ----------------------------------------------------------------------------
module soc_system_dp_ram_pipelined_rdpipe #(
    parameter int DATA_WIDTH   = 128,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_accept,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_readdata,
    output logic                  o_readdatavalid
);

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s1_valid;
            logic [DATA_WIDTH-1:0] r_s1_data;
            logic                  r_valid;
            logic [DATA_WIDTH-1:0] r_data;

            // Two-stage return: capture at accept, present one cycle later.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_valid    <= 1'b0;
                    r_data     <= '0;
                end else begin
                    r_s1_valid <= i_accept;
                    if (i_accept) begin
                        r_s1_data <= i_data;
                    end
                    r_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_data <= r_s1_data;
                    end
                end
            end

            assign o_readdata      = r_data;
            assign o_readdatavalid = r_valid;
        end else begin : g_lat1
            logic                  r_valid;
            logic [DATA_WIDTH-1:0] r_data;

            // Single-stage return: the registered read is the output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= i_accept;
                    if (i_accept) begin
                        r_data <= i_data;
                    end
                end
            end

            assign o_readdata      = r_data;
            assign o_readdatavalid = r_valid;
        end
    endgenerate

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module soc_system_dp_ram_pipelined #(
    parameter int                  DATA_WIDTH     = 128,
    parameter int                  DEPTH          = 64,
    parameter int                  ADDR_WIDTH     = 6,
    parameter int                  READ_LATENCY   = 1,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    // port A (s1)
    input  logic [ADDR_WIDTH-1:0]   address_a,
    input  logic [DATA_WIDTH/8-1:0] byteenable_a,
    input  logic                    chipselect_a,
    input  logic                    read_a,
    input  logic                    write_a,
    input  logic [DATA_WIDTH-1:0]   writedata_a,
    output logic [DATA_WIDTH-1:0]   readdata_a,
    output logic                    readdatavalid_a,
    output logic                    waitrequest_a,
    // port B (s2)
    input  logic [ADDR_WIDTH-1:0]   address_b,
    input  logic [DATA_WIDTH/8-1:0] byteenable_b,
    input  logic                    chipselect_b,
    input  logic                    read_b,
    input  logic                    write_b,
    input  logic [DATA_WIDTH-1:0]   writedata_b,
    output logic [DATA_WIDTH-1:0]   readdata_b,
    output logic                    readdatavalid_b,
    output logic                    waitrequest_b,
    // status
    output logic                    init_done,
    output logic [15:0]             collision_count
);

    localparam int                  c_BE_W      = DATA_WIDTH / 8;
    localparam int                  c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDX_W-1:0]   r_clr_addr;
    logic [c_IDX_W-1:0]   w_clr_addr_next;
    logic                 w_clr_we;
    logic                 r_waitrequest;
    logic                 r_init_done;
    logic [15:0]          r_collision_count;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Request decode. Nothing is accepted on a reset edge, and read+write
    // together is a write only.
    // ------------------------------------------------------------------------
    logic                  w_in_range_a, w_in_range_b;
    logic [c_IDX_W-1:0]    w_idx_a, w_idx_b;
    logic                  w_acc_wr_a, w_acc_wr_b;
    logic                  w_acc_rd_a, w_acc_rd_b;
    logic                  w_wr_en_a, w_wr_en_b;
    logic [DATA_WIDTH-1:0] w_rd_word_a, w_rd_word_b;
    logic                  w_collide;

    assign w_in_range_a = ({1'b0, address_a} < c_DEPTH_EXT);
    assign w_in_range_b = ({1'b0, address_b} < c_DEPTH_EXT);
    assign w_idx_a      = address_a[c_IDX_W-1:0];
    assign w_idx_b      = address_b[c_IDX_W-1:0];

    assign w_acc_wr_a = chipselect_a & write_a & ~r_waitrequest & ~reset;
    assign w_acc_wr_b = chipselect_b & write_b & ~r_waitrequest & ~reset;
    assign w_acc_rd_a = chipselect_a & read_a & ~write_a & ~r_waitrequest & ~reset;
    assign w_acc_rd_b = chipselect_b & read_b & ~write_b & ~r_waitrequest & ~reset;

    // Out-of-range writes are silently dropped.
    assign w_wr_en_a = w_acc_wr_a & w_in_range_a;
    assign w_wr_en_b = w_acc_wr_b & w_in_range_b;

    // Words as they stand before this edge's writes: a same-cycle write on
    // the other port is not visible to the read. Out-of-range reads give 0.
    assign w_rd_word_a = w_in_range_a ? r_mem[w_idx_a] : '0;
    assign w_rd_word_b = w_in_range_b ? r_mem[w_idx_b] : '0;

    // Both ports writing overlapping lanes of the same word.
    assign w_collide = w_wr_en_a & w_wr_en_b & (w_idx_a == w_idx_b) &
                       (|(byteenable_a & byteenable_b));

    // ------------------------------------------------------------------------
    // Control FSM: CLEAR walks every word once, then RUN until reset.
    // ------------------------------------------------------------------------

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_addr    <= '0;
            r_waitrequest <= 1'b1;
            r_init_done   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_clr_addr    <= w_clr_addr_next;
            r_waitrequest <= (w_state_next != ST_RUN);
            r_init_done   <= (w_state_next == ST_RUN);
        end
    end

    // Next-state and clear-write strobe.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_clr_we        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = ~reset;
                if (r_clr_addr == c_LAST_IDX) begin
                    w_state_next    = ST_RUN;
                    w_clr_addr_next = '0;
                end else begin
                    w_clr_addr_next = r_clr_addr + c_IDX_W'(1);
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage. Port B's lanes are scheduled first so that port A's later
    // assignment wins on any lane both ports enable in the same cycle.
    // ------------------------------------------------------------------------

    // Clear fill, or byte-lane writes from both ports.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= INIT_VALUE;
        end else begin
            if (w_wr_en_b) begin
                for (int l = 0; l < c_BE_W; l++) begin
                    if (byteenable_b[l]) begin
                        r_mem[w_idx_b][l*8 +: 8] <= writedata_b[l*8 +: 8];
                    end
                end
            end
            if (w_wr_en_a) begin
                for (int l = 0; l < c_BE_W; l++) begin
                    if (byteenable_a[l]) begin
                        r_mem[w_idx_a][l*8 +: 8] <= writedata_a[l*8 +: 8];
                    end
                end
            end
        end
    end

    // Saturating count of overlapping dual writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_collision_count <= 16'd0;
        end else if (w_collide && (r_collision_count != 16'hFFFF)) begin
            r_collision_count <= r_collision_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Read return paths
    // ------------------------------------------------------------------------
    soc_system_dp_ram_pipelined_rdpipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_a (
        .clk             (clk),
        .rst             (reset),
        .i_accept        (w_acc_rd_a),
        .i_data          (w_rd_word_a),
        .o_readdata      (readdata_a),
        .o_readdatavalid (readdatavalid_a)
    );

    soc_system_dp_ram_pipelined_rdpipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_b (
        .clk             (clk),
        .rst             (reset),
        .i_accept        (w_acc_rd_b),
        .i_data          (w_rd_word_b),
        .o_readdata      (readdata_b),
        .o_readdatavalid (readdatavalid_b)
    );

    assign waitrequest_a   = r_waitrequest;
    assign waitrequest_b   = r_waitrequest;
    assign init_done       = r_init_done;
    assign collision_count = r_collision_count;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_dp_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_dp_ram_pipelined
// Brief    : Self-checking bench. Two instances: dut0 = defaults (64 words,
//            latency 1, clear on reset); dut1 = 40 words in a 6-bit address
//            space, latency 2, contents kept across reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soc_system_dp_ram_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index [k][p]: k = instance, p = port (0 = A, 1 = B)
    logic         rst   [2];
    logic [5:0]   addr  [2][2];
    logic [15:0]  be    [2][2];
    logic         cs    [2][2];
    logic         rd    [2][2];
    logic         wr    [2][2];
    logic [127:0] wd    [2][2];
    logic [127:0] rdata [2][2];
    logic         rdv   [2][2];
    logic         wreq  [2][2];
    logic         idone [2];
    logic [15:0]  ccnt  [2];

    soc_system_dp_ram_pipelined u_dut0 (
        .clk(clk), .reset(rst[0]),
        .address_a(addr[0][0]), .byteenable_a(be[0][0]), .chipselect_a(cs[0][0]),
        .read_a(rd[0][0]), .write_a(wr[0][0]), .writedata_a(wd[0][0]),
        .readdata_a(rdata[0][0]), .readdatavalid_a(rdv[0][0]), .waitrequest_a(wreq[0][0]),
        .address_b(addr[0][1]), .byteenable_b(be[0][1]), .chipselect_b(cs[0][1]),
        .read_b(rd[0][1]), .write_b(wr[0][1]), .writedata_b(wd[0][1]),
        .readdata_b(rdata[0][1]), .readdatavalid_b(rdv[0][1]), .waitrequest_b(wreq[0][1]),
        .init_done(idone[0]), .collision_count(ccnt[0])
    );

    soc_system_dp_ram_pipelined #(
        .DATA_WIDTH(128), .DEPTH(40), .ADDR_WIDTH(6), .READ_LATENCY(2),
        .CLEAR_ON_RESET(0), .INIT_VALUE('0)
    ) u_dut1 (
        .clk(clk), .reset(rst[1]),
        .address_a(addr[1][0]), .byteenable_a(be[1][0]), .chipselect_a(cs[1][0]),
        .read_a(rd[1][0]), .write_a(wr[1][0]), .writedata_a(wd[1][0]),
        .readdata_a(rdata[1][0]), .readdatavalid_a(rdv[1][0]), .waitrequest_a(wreq[1][0]),
        .address_b(addr[1][1]), .byteenable_b(be[1][1]), .chipselect_b(cs[1][1]),
        .read_b(rd[1][1]), .write_b(wr[1][1]), .writedata_b(wd[1][1]),
        .readdata_b(rdata[1][1]), .readdatavalid_b(rdv[1][1]), .waitrequest_b(wreq[1][1]),
        .init_done(idone[1]), .collision_count(ccnt[1])
    );

    int vecs  = 0;
    int fails = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 64 : 40;
    endfunction
    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic bit clr(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a word array plus a small schedule of read returns
    // keyed by the edge number on which each one becomes visible.
    // ------------------------------------------------------------------------
    logic [127:0] m_mem  [2][64];
    bit           m_live [2];
    bit           m_wait [2];
    int           m_left [2];
    logic [15:0]  m_cnt  [2];
    bit           m_sv   [2][2][4];
    logic [127:0] m_sd   [2][2][4];
    bit           m_rdv  [2][2];
    logic [127:0] m_rd   [2][2];
    int           ecnt = 0;

    task automatic model_edge(input int k);
        bit aw [2];
        bit ar [2];
        int s;
        int a;
        if (rst[k]) begin
            m_live[k] = 1'b1;
            m_wait[k] = 1'b1;
            m_cnt[k]  = 16'd0;
            m_left[k] = clr(k) ? dep(k) : 0;
            if (clr(k)) begin
                for (int i = 0; i < 64; i++) m_mem[k][i] = '0;
            end
            for (int p = 0; p < 2; p++) begin
                for (int j = 0; j < 4; j++) m_sv[k][p][j] = 1'b0;
                m_rdv[k][p] = 1'b0;
                m_rd[k][p]  = '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                aw[p] = !m_wait[k] && cs[k][p] && wr[k][p];
                ar[p] = !m_wait[k] && cs[k][p] && rd[k][p] && !wr[k][p];
            end
            // reads see the array as it was before this edge's writes
            for (int p = 0; p < 2; p++) begin
                if (ar[p]) begin
                    a = int'(addr[k][p]);
                    s = (ecnt + lat(k) - 1) % 4;
                    m_sv[k][p][s] = 1'b1;
                    m_sd[k][p][s] = (a < dep(k)) ? m_mem[k][a] : 128'd0;
                end
            end
            if (aw[0] && aw[1] && addr[k][0] == addr[k][1] && int'(addr[k][0]) < dep(k) &&
                (be[k][0] & be[k][1]) != 16'd0 && m_cnt[k] != 16'hFFFF)
                m_cnt[k] = m_cnt[k] + 16'd1;
            // B first, then A: A owns lanes both enable
            for (int p = 1; p >= 0; p--) begin
                a = int'(addr[k][p]);
                if (aw[p] && a < dep(k)) begin
                    for (int b = 0; b < 16; b++)
                        if (be[k][p][b]) m_mem[k][a][b*8 +: 8] = wd[k][p][b*8 +: 8];
                end
            end
            if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
            m_wait[k] = (m_left[k] != 0);
            for (int p = 0; p < 2; p++) begin
                s = ecnt % 4;
                m_rdv[k][p] = m_sv[k][p][s];
                if (m_sv[k][p][s]) begin
                    m_rd[k][p]    = m_sd[k][p][s];
                    m_sv[k][p][s] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_edge(k);
        ecnt++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_live[k]) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("cmp.dut%0d.p%0d.rdv", k, p), rdv[k][p], m_rdv[k][p]);
                    chk($sformatf("cmp.dut%0d.p%0d.rdata", k, p), rdata[k][p], m_rd[k][p]);
                    chk($sformatf("cmp.dut%0d.p%0d.wreq", k, p), wreq[k][p], m_wait[k]);
                end
                chk($sformatf("cmp.dut%0d.init_done", k), idone[k], !m_wait[k]);
                chk($sformatf("cmp.dut%0d.ccnt", k), ccnt[k], m_cnt[k]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change only at negedge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int p = 0; p < 2; p++) begin
            cs[k][p] = 0; rd[k][p] = 0; wr[k][p] = 0;
            addr[k][p] = '0; be[k][p] = '0; wd[k][p] = '0;
        end
    endtask

    task automatic drv(input int k, input int p, input bit w, input bit r, input int a,
                       input logic [127:0] d, input logic [15:0] b);
        cs[k][p] = 1'b1; wr[k][p] = w; rd[k][p] = r;
        addr[k][p] = 6'(a); wd[k][p] = d; be[k][p] = b;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            idle(k);
        end
        @(negedge clk);
        repeat (3) step();
        chk("rst.wreq", wreq[0][0], 1'b1);
        chk("rst.init_done", idone[0], 1'b0);
        chk("rst.rdv", rdv[0][1], 1'b0);
        chk("rst.rdata", rdata[0][0], 128'd0);
        chk("rst.ccnt", ccnt[0], 16'd0);

        // release both; dut0 clears for 64 cycles, dut1 runs next cycle
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk("dut1.wreq_at_deassert", wreq[1][0], 1'b1);
        n = 0;
        while (wreq[0][0] && n < 200) begin
            n++;
            step();
            if (n == 1) begin
                chk("dut1.wreq_one_after", wreq[1][1], 1'b0);
                chk("dut1.init_one_after", idone[1], 1'b1);
            end
        end
        chk("clear.cycles", 128'(n), 128'd64);
        chk("clear.init_done", idone[0], 1'b1);

        // cleared word, latency 1
        drv(0, 0, 0, 1, 63, '0, '0); step(); idle(0);
        chk("clear.read_rdv", rdv[0][0], 1'b1);
        chk("clear.read_data", rdata[0][0], 128'd0);

        // byte-enable merge
        drv(0, 0, 1, 0, 5, {16{8'hFF}}, 16'hFFFF); step();
        drv(0, 0, 1, 0, 5, {16{8'h11}}, 16'h0001); step(); idle(0);
        drv(0, 1, 0, 1, 5, '0, '0); step(); idle(0);
        chk("be.rdv", rdv[0][1], 1'b1);
        chk("be.data", rdata[0][1], {{15{8'hFF}}, 8'h11});

        // overlapping dual write
        drv(0, 0, 1, 0, 9, {16{8'h11}}, 16'h00FF);
        drv(0, 1, 1, 0, 9, {16{8'h22}}, 16'h0FF0); step(); idle(0);
        chk("coll.count1", ccnt[0], 16'd1);
        drv(0, 0, 0, 1, 9, '0, '0); step(); idle(0);
        chk("coll.data", rdata[0][0], {32'h0, 32'h2222_2222, 64'h1111_1111_1111_1111});
        // disjoint lanes: no count
        drv(0, 0, 1, 0, 10, {16{8'h11}}, 16'h00FF);
        drv(0, 1, 1, 0, 10, {16{8'h22}}, 16'hFF00); step(); idle(0);
        chk("coll.count_unchanged", ccnt[0], 16'd1);
        drv(0, 1, 0, 1, 10, '0, '0); step(); idle(0);
        chk("coll.disjoint_data", rdata[0][1], {{8{8'h22}}, {8{8'h11}}});

        // write on A, read same word on B in the same cycle
        drv(0, 0, 1, 0, 7, {16{8'h33}}, 16'hFFFF); step();
        drv(0, 0, 1, 0, 7, {16{8'h55}}, 16'hFFFF);
        drv(0, 1, 0, 1, 7, '0, '0); step(); idle(0);
        chk("mixed.old", rdata[0][1], {16{8'h33}});
        drv(0, 1, 0, 1, 7, '0, '0); step(); idle(0);
        chk("mixed.new", rdata[0][1], {16{8'h55}});

        // same-port write then read
        drv(0, 0, 1, 0, 12, {16{8'h77}}, 16'hFFFF); step();
        drv(0, 0, 0, 1, 12, '0, '0); step(); idle(0);
        chk("wr_then_rd", rdata[0][0], {16{8'h77}});

        // dut1: preload every word, then pipelined reads at latency 2
        for (int i = 0; i < 40; i++) begin
            drv(1, 0, 1, 0, i, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
            step();
        end
        drv(1, 0, 1, 0, 1, 128'hA, 16'hFFFF); step();
        drv(1, 0, 1, 0, 2, 128'hB, 16'hFFFF); step();
        drv(1, 0, 1, 0, 3, 128'hC, 16'hFFFF); step();
        drv(1, 0, 0, 1, 1, '0, '0); step();
        chk("lat2.not_yet", rdv[1][0], 1'b0);
        drv(1, 0, 0, 1, 2, '0, '0); step();
        chk("lat2.v0", rdv[1][0], 1'b1); chk("lat2.d0", rdata[1][0], 128'hA);
        drv(1, 0, 0, 1, 3, '0, '0); step(); idle(1);
        chk("lat2.v1", rdv[1][0], 1'b1); chk("lat2.d1", rdata[1][0], 128'hB);
        step();
        chk("lat2.v2", rdv[1][0], 1'b1); chk("lat2.d2", rdata[1][0], 128'hC);
        step();
        chk("lat2.end", rdv[1][0], 1'b0);

        // out-of-range: write dropped, read returns 0
        drv(1, 1, 1, 0, 50, {16{8'hEE}}, 16'hFFFF); step();
        drv(1, 1, 0, 1, 50, '0, '0); step(); idle(1); step();
        chk("oor.rdv", rdv[1][1], 1'b1);
        chk("oor.data", rdata[1][1], 128'd0);

        // reset while a read is in flight
        drv(1, 0, 0, 1, 2, '0, '0); step(); idle(1);
        rst[1] = 1'b1; step();
        chk("midrst.rdv0", rdv[1][0], 1'b0); step();
        chk("midrst.rdv1", rdv[1][0], 1'b0);
        rst[1] = 1'b0;
        chk("midrst.wreq_deassert", wreq[1][0], 1'b1); step();
        chk("midrst.wreq_after", wreq[1][0], 1'b0);
        drv(1, 0, 0, 1, 2, '0, '0); step(); idle(1); step();
        chk("midrst.kept_v", rdv[1][0], 1'b1);
        chk("midrst.kept_d", rdata[1][0], 128'hB);

        // randomized traffic on both instances, with one reset in the middle
        for (int k = 0; k < 2; k++) begin
            for (int it = 0; it < 1500; it++) begin
                rst[k] = (it == 700 || it == 701);
                for (int p = 0; p < 2; p++) begin
                    cs[k][p]   = ($urandom % 4) != 0;
                    rd[k][p]   = $urandom % 2;
                    wr[k][p]   = ($urandom % 3) == 0;
                    addr[k][p] = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom % 64);
                    be[k][p]   = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
                    wd[k][p]   = {$urandom, $urandom, $urandom, $urandom};
                end
                step();
            end
            rst[k] = 1'b0;
            idle(k);
            repeat (4) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc_system_dp_ram_pipelined.md
Name: soc_system_dp_ram_pipelined

Overview:
Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1 = port A, s2 = port B) on one clock.
It replaces the fixed 128x64 unregistered-output memory with configurable width, depth and read latency.
It adds readdatavalid/waitrequest handshakes, a post-reset clear sequencer and deterministic mixed-port collision rules.
It sits on the HPS-to-FPGA bridge fabric as a shared scratchpad between the HPS and fabric masters.

Parameters:
DATA_WIDTH, 128, data bits per word; multiple of 8.
DEPTH, 64, number of words; 2..4096.
ADDR_WIDTH, 6, address bits; must be >= clog2(DEPTH).
READ_LATENCY, 1, accept-to-readdatavalid cycles; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = write INIT_VALUE to all words after reset.
INIT_VALUE, 0, DATA_WIDTH-bit fill pattern used by the clear sequence.

Ports:
clk  in  1  single clock for both ports
reset  in  1  synchronous, active-high
address_a / address_b  in  ADDR_WIDTH  word address
byteenable_a / byteenable_b  in  DATA_WIDTH/8  byte-lane write enables
chipselect_a / chipselect_b  in  1  port select
read_a / read_b  in  1  read request
write_a / write_b  in  1  write request
writedata_a / writedata_b  in  DATA_WIDTH  write data
readdata_a / readdata_b  out  DATA_WIDTH  read data
readdatavalid_a / readdatavalid_b  out  1  readdata qualifier
waitrequest_a / waitrequest_b  out  1  port stall
init_done  out  1  clear sequence finished; ports usable
collision_count  out  16  saturating count of same-address dual-write overlaps

Behaviour:
- Reset is sampled on the clk edge. While reset is high:
  - readdata_* = 0, readdatavalid_* = 0, waitrequest_* = 1, init_done = 0.
  - collision_count = 0; clear counter = 0; FSM = CLEAR (or RUN if CLEAR_ON_RESET = 0).
  - Pending read pipeline entries are discarded.
- FSM CLEAR:
  - Each cycle writes INIT_VALUE to word clr_addr, then clr_addr++.
  - waitrequest_* = 1; incoming requests are ignored.
  - After the write to DEPTH-1, transition to RUN. CLEAR lasts exactly DEPTH cycles.
- FSM RUN:
  - waitrequest_* = 0 and init_done = 1, registered. Both first go true on the cycle after the last clear write, or on the first cycle after reset deasserts when CLEAR_ON_RESET = 0.
  - RUN persists until reset.
- Transfer acceptance: a transfer is accepted when chipselect & (read | write) & !waitrequest.
  - read and write both high: treated as a write only; no readdatavalid.
- Writes: only byte lanes with byteenable = 1 are updated, at the accept edge. byteenable = 0 lanes are unchanged.
- Reads:
  - Fully pipelined; one accept per port per cycle.
  - readdatavalid pulses exactly READ_LATENCY cycles after accept, with readdata = word contents at the accept edge.
  - readdata holds its last value when readdatavalid = 0.
- Same-port write at cycle N followed by read of the same address at N+1 returns the new data.
- Same-cycle mixed-port collisions at the same address:
  - Write on one port + read on the other: the read returns old data.
  - Both ports write:
    - Lanes enabled on A only take A's data; lanes enabled on B only take B's data.
    - Lanes enabled on both take A's data.
    - If any lane overlaps, collision_count increments by 1, saturating at 0xFFFF.
- Out-of-range address (>= DEPTH): write is dropped; read returns 0 with normal readdatavalid timing.
- Reset asserted mid-operation: no readdatavalid is produced for reads accepted before reset.
  - Memory is cleared again if CLEAR_ON_RESET = 1; otherwise contents are preserved.

Test Plan:
- Clear sequence (defaults): deassert reset -> waitrequest_a/b = 1 for 64 cycles, then init_done = 1. A read of address 0x3F then returns 0, with readdatavalid 1 cycle after accept.
- Byte-enable write: write A addr 5, data all 0xFF bytes, byteenable = 0xFFFF; then write A addr 5, data 0x11 per byte, byteenable = 0x0001; read B addr 5 -> readdata = 0xFF..FF11.
- Pipelined reads, READ_LATENCY = 2: back-to-back reads on A of addr 1, 2, 3 (preloaded 0xA, 0xB, 0xC) -> readdatavalid high on 3 consecutive cycles, starting 2 cycles after the first accept, data 0xA, 0xB, 0xC in order.
- Dual-write collision:
  - Same cycle: A writes addr 9, data 0x1111.., byteenable 0x00FF; B writes addr 9, data 0x2222.., byteenable 0x0FF0.
  - Expected: lanes 0-7 = 0x11, lanes 8-11 = 0x22, lanes 12-15 unchanged; collision_count = 1.
  - Non-overlapping byteenables (0x00FF / 0xFF00) -> count unchanged.
- Mixed read/write: A writes addr 7 = 0x55.. while B reads addr 7 (old 0x33..) in the same cycle -> B readdata = 0x33..; a B read on the next cycle -> 0x55...
- Reset mid-flight, CLEAR_ON_RESET = 0: accept a read, assert reset the next cycle -> no readdatavalid. After reset, waitrequest = 0 one cycle after deassert, and previously written data is intact.
